// File: rtl/mdu_pkg.sv
// Shared op encodings and FSM state type for the multiply/divide unit.
package mdu_pkg;

  localparam logic [2:0] OP_MULTU = 3'b000;
  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_DIVU  = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;
  localparam logic [2:0] OP_MADD  = 3'b110;
  localparam logic [2:0] OP_MSUB  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_FIX
  } mdu_state_e;

endpackage

// File: rtl/mdu_div_iter.sv
// Radix-2 restoring divider datapath: one quotient bit per step on unsigned magnitudes.
// Divisor zero naturally yields an all-ones quotient and the dividend as remainder.
module mdu_div_iter
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             clear,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             last_c
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] dvs;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   shifted_c;
  logic             ge_c;

  always_comb begin
    shifted_c = {remainder, quotient[WIDTH-1]};
    ge_c      = shifted_c >= {1'b0, dvs};
    last_c    = (cnt == CNT_W'(WIDTH - 1));
  end

  // Quotient register doubles as the dividend shift register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quotient  <= '0;
      remainder <= '0;
      dvs       <= '0;
      cnt       <= '0;
    end else if (clear) begin
      quotient  <= '0;
      remainder <= '0;
      dvs       <= '0;
      cnt       <= '0;
    end else if (load) begin
      quotient  <= dividend;
      remainder <= '0;
      dvs       <= divisor;
      cnt       <= '0;
    end else if (step) begin
      remainder <= ge_c ? WIDTH'(shifted_c - {1'b0, dvs}) : shifted_c[WIDTH-1:0];
      quotient  <= {quotient[WIDTH-2:0], ge_c};
      cnt       <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/mdu_ctrl.sv
// EXE-stage multiply/divide controller and HI/LO owner (pipelined multiply, iterative divide).
// Define MDU_MACC_EN to enable MADD/MSUB (ops 110/111); otherwise those ops are no-ops.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(MUL_STAGES + 2);

  mdu_state_e                   state;
  logic [CNT_W-1:0]             mul_cnt;
  logic [MUL_STAGES-1:0][PW-1:0] pipe;
  logic                         q_neg, r_neg;
`ifdef MDU_MACC_EN
  logic                         macc, msub;
`endif

  logic             op_signed_c, op_mul_c, op_div_c, accept_c;
  logic             mul_load_c, div_load_c, div_step_c, div_last_c;
  logic [PW-1:0]    a_ext_c, b_ext_c, prod_c, mul_res_c;
  logic [WIDTH-1:0] a_mag_c, b_mag_c, quo, rem;
  logic [CNT_W-1:0] mul_last_c;

  always_comb begin
    op_signed_c = (op != OP_MULTU) && (op != OP_DIVU);
`ifdef MDU_MACC_EN
    op_mul_c    = (op == OP_MULTU) || (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
`else
    op_mul_c    = (op == OP_MULTU) || (op == OP_MULT);
`endif
    op_div_c    = (op == OP_DIVU) || (op == OP_DIV);
    accept_c    = (state == ST_IDLE) && start && !flush;
    mul_load_c  = accept_c && op_mul_c;
    div_load_c  = accept_c && op_div_c;
    div_step_c  = (state == ST_DIV) && !flush;
    a_ext_c     = {{WIDTH{op_signed_c & a[WIDTH-1]}}, a};
    b_ext_c     = {{WIDTH{op_signed_c & b[WIDTH-1]}}, b};
    prod_c      = a_ext_c * b_ext_c;
    a_mag_c     = (op_signed_c && a[WIDTH-1]) ? -a : a;
    b_mag_c     = (op_signed_c && b[WIDTH-1]) ? -b : b;
`ifdef MDU_MACC_EN
    mul_last_c  = macc ? CNT_W'(MUL_STAGES) : CNT_W'(MUL_STAGES - 1);
    if (!macc)     mul_res_c = pipe[MUL_STAGES-1];
    else if (msub) mul_res_c = {hi, lo} - pipe[MUL_STAGES-1];
    else           mul_res_c = {hi, lo} + pipe[MUL_STAGES-1];
`else
    mul_last_c  = CNT_W'(MUL_STAGES - 1);
    mul_res_c   = pipe[MUL_STAGES-1];
`endif
  end

  // Product enters stage 0 at the start edge and ripples to the last stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pipe <= '0;
    end else begin
      if (mul_load_c) pipe[0] <= prod_c;
      for (int i = 1; i < MUL_STAGES; i++) pipe[i] <= pipe[i-1];
    end
  end

  mdu_div_iter #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .load      (div_load_c),
    .step      (div_step_c),
    .clear     (flush),
    .dividend  (a_mag_c),
    .divisor   (b_mag_c),
    .quotient  (quo),
    .remainder (rem),
    .last_c    (div_last_c)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      mul_cnt <= '0;
      q_neg   <= 1'b0;
      r_neg   <= 1'b0;
`ifdef MDU_MACC_EN
      macc    <= 1'b0;
      msub    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: if (start) begin
            case (op)
              OP_MTHI: hi <= a;
              OP_MTLO: lo <= a;
              OP_DIVU, OP_DIV: begin
                state <= ST_DIV;
                busy  <= 1'b1;
                q_neg <= op_signed_c & (a[WIDTH-1] ^ b[WIDTH-1]);
                r_neg <= op_signed_c & a[WIDTH-1];
              end
              default: if (op_mul_c) begin
                state   <= ST_MUL;
                busy    <= 1'b1;
                mul_cnt <= '0;
`ifdef MDU_MACC_EN
                macc    <= (op == OP_MADD) || (op == OP_MSUB);
                msub    <= (op == OP_MSUB);
`endif
              end
            endcase
          end
          ST_MUL: begin
            if (mul_cnt == mul_last_c) begin
              {hi, lo} <= mul_res_c;
              state    <= ST_IDLE;
              busy     <= 1'b0;
              done     <= 1'b1;
            end else begin
              mul_cnt <= mul_cnt + CNT_W'(1);
            end
          end
          ST_DIV: if (div_last_c) state <= ST_FIX;
          ST_FIX: begin
            lo    <= q_neg ? -quo : quo;
            hi    <= r_neg ? -rem : rem;
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multi-cycle multiply/divide controller and HI/LO register owner for the EXE stage, successor to the decoder's fixed 2-bit multiply/divide op and single-cycle HI/LO write scheme. Accepts one MDU operation at a time and runs multiplies through a MUL_STAGES-deep pipeline and divides through a radix-2 iterative divider. Holds HI/LO and exposes `busy` so the hazard unit can stall dependent MFHI/MFLO and further MDU ops. Supports pipeline flush of an in-flight operation.

## Interface
- `WIDTH`, 32, operand width; HI/LO each WIDTH bits.
- `MUL_STAGES`, 2, multiplier pipeline depth (>=1).
- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `start` input 1: operation request from EXE, valid for one cycle.
- `op` input 3: 000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO, 110 MADD, 111 MSUB.
- `a` input WIDTH: rs operand (dividend / multiplicand / MT source).
- `b` input WIDTH: rt operand (divisor / multiplier).
- `flush` input 1: abort in-flight op (exception/eret).
- `busy` output 1: registered, high while state != IDLE.
- `done` output 1: one-cycle pulse in the cycle HI/LO show a multi-cycle result.
- `hi` output WIDTH: HI register.
- `lo` output WIDTH: LO register.

## Operation
- Reset: state IDLE; `hi`, `lo` = 0; `busy`, `done` = 0; pipeline/divider contents cleared.
- States: IDLE, MUL, DIV, FIX.
- IDLE + `start` + MTHI/MTLO: write `a` to HI/LO at that edge; stay IDLE; no `done`.
- IDLE + `start` + MULT/MULTU (+ MADD/MSUB when enabled): latch operands, go MUL; counter counts MUL_STAGES; product {HI,LO} (2*WIDTH) written on last stage; back to IDLE.
- IDLE + `start` + DIV/DIVU: latch |a|,|b| (signed) or a,b; go DIV; WIDTH restoring iterations; go FIX; FIX applies signs and writes LO=quotient, HI=remainder; back to IDLE.
- Signed divide: quotient negated iff signs differ; remainder takes sign of `a`. MIN/-1: LO=0x80000000 (WIDTH=32), HI=0.
- Divide by zero: no trap; magnitude result quotient all-ones, remainder |a|, then sign fix. DIVU 5/0: LO=0xFFFFFFFF, HI=5.
- `start` while `busy`: ignored (hazard unit must stall instead).
- `flush`: any state -> IDLE next edge; HI/LO unchanged; no `done`. `flush` with `start` in IDLE: start ignored, including MTHI/MTLO.
- Reset mid-operation: immediate return to reset values.

## Timing
- Start edge = edge T0 at which `start` is sampled in IDLE.
- MUL: `busy` high from T0+1; HI/LO updated at edge T0+MUL_STAGES; `done` high and `busy` low in cycle after that edge.
- MADD/MSUB: one extra accumulate cycle; HI/LO at T0+MUL_STAGES+1.
- DIV: HI/LO updated at edge T0+WIDTH+1 (WIDTH iterations + FIX); `done` in following cycle; 33-cycle divide at WIDTH=32.
- MTHI/MTLO: HI/LO visible cycle after T0; `busy` never asserted.
- A new `start` is accepted in the `done` cycle (back-to-back).

## Configuration
- `MDU_MACC_EN` defined: ops 110 MADD / 111 MSUB: {HI,LO} +/- signed product of a,b, mod 2^(2*WIDTH).
- Not defined: ops 110/111 ignored as no-op (no state change, no `busy`, no `done`, HI/LO unchanged); accumulate adder absent.

## Structure
- Package `mdu_pkg`: op encoding constants, state enum (IDLE/MUL/DIV/FIX).
- Sub-module `mdu_div_iter`: radix-2 restoring divider datapath (partial remainder, quotient shift, iteration counter, load/step/clear controls). Multiplier pipeline and FSM stay in `mdu_ctrl`.

## Test plan
- MULT a=0xFFFFFFFF, b=2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE at T0+2; MULTU same -> HI=0x00000001, LO=0xFFFFFFFE; `done` one cycle.
- DIVU 7/2 -> LO=3, HI=1 at T0+33; DIV -7/2 (0xFFFFFFF9) -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
- DIVU 5/0 -> LO=0xFFFFFFFF, HI=5, no exception.
- DIV started with HI=0x11, LO=0x22, `flush` at T0+10 -> IDLE at T0+11, HI/LO unchanged, no `done`; `start` during `busy` ignored.
- MTHI 0xABCD then MTLO 0x1234 on consecutive cycles -> HI=0xABCD, LO=0x1234, `busy` never high; `rst` low mid-DIV -> all outputs 0 immediately.
- With `MDU_MACC_EN`: HI=0, LO=10, MADD 3*4 -> LO=22; MSUB 5*5 -> {HI,LO}=0xFFFFFFFF_FFFFFFFD. Without: op 110 leaves HI/LO unchanged, `busy` low.
